// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types and constants for the parking slot allocator
package slot_pkg;

  localparam int SLOT_W    = 4;
  localparam int NUM_SLOTS = 16;

  typedef logic [SLOT_W-1:0] slot_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_t;

  // Bit i set when slot i carries a charger (slots 0..n-1).
  function automatic logic [NUM_SLOTS-1:0] charger_mask(input int n);
    logic [NUM_SLOTS-1:0] mask;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      mask[i] = (i < n);
    end
    return mask;
  endfunction

endpackage

// File: rtl/slot_pick.sv
// rtl/slot_pick.sv - lowest-index priority encoder over free & allowed slot masks
module slot_pick
  import slot_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] free_mask_i,
  input  logic [NUM_SLOTS-1:0] allowed_mask_i,
  output logic                 found_o,
  output slot_idx_t            idx_o
);

  logic [NUM_SLOTS-1:0] cand;

  assign cand = free_mask_i & allowed_mask_i;

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    found_o = |cand;
    idx_o   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        idx_o = slot_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// rtl/slot_allocator.sv - occupancy map, slot grant/free and entry-gate timer; SLOT_CHARGE_PRIORITY_EN enables charger-aware placement
module slot_allocator
  import slot_pkg::*;
#(
  parameter int CHARGE_SLOTS = 4,
  parameter int GATE_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              car_arrive,
  input  logic              arrive_charge,
  input  logic              car_leave,
  input  logic [SLOT_W-1:0] leave_slot,
  output logic              sensor_entry,
  output logic [SLOT_W-1:0] entry_slot,
  output logic              want_to_charge,
  output logic              sensor_exit,
  output logic [SLOT_W-1:0] exit_slot,
  output logic              reject,
  output logic              leave_err,
  output logic              gate_open,
  output logic              lot_full,
  output logic [SLOT_W:0]   free_count
);

  localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  if (CHARGE_SLOTS < 0 || CHARGE_SLOTS > NUM_SLOTS || GATE_CYCLES < 1) begin : g_bad_config
    $error("slot_allocator: CHARGE_SLOTS must be 0..16 and GATE_CYCLES >= 1");
  end

  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SLOT_W:0]      free_q, free_d;
  gate_state_t          state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 sensor_entry_q, want_q, sensor_exit_q, reject_q, leave_err_q;
  slot_idx_t            entry_slot_q, exit_slot_q;

  logic [NUM_SLOTS-1:0] free_mask;
  logic                 pick_found;
  slot_idx_t            pick_idx;
  logic                 arrive_live, grant, refuse, leave_hit, leave_miss;

  assign free_mask = ~occ_q;

`ifdef SLOT_CHARGE_PRIORITY_EN
  localparam logic [NUM_SLOTS-1:0] CHG_MASK = charger_mask(CHARGE_SLOTS);

  logic      main_found, plain_found;
  slot_idx_t main_idx, plain_idx;

  // Charging cars are confined to charger slots; others search the whole lot here.
  slot_pick u_pick_main (
    .free_mask_i    (free_mask),
    .allowed_mask_i (arrive_charge ? CHG_MASK : {NUM_SLOTS{1'b1}}),
    .found_o        (main_found),
    .idx_o          (main_idx)
  );

  slot_pick u_pick_plain (
    .free_mask_i    (free_mask),
    .allowed_mask_i (~CHG_MASK),
    .found_o        (plain_found),
    .idx_o          (plain_idx)
  );

  // Non-charging cars keep chargers free unless nothing else is left.
  assign pick_found = main_found;
  assign pick_idx   = (!arrive_charge && plain_found) ? plain_idx : main_idx;
`else
  slot_pick u_pick_main (
    .free_mask_i    (free_mask),
    .allowed_mask_i ({NUM_SLOTS{1'b1}}),
    .found_o        (pick_found),
    .idx_o          (pick_idx)
  );
`endif

  assign arrive_live = car_arrive && (state_q == IDLE);
  assign grant       = arrive_live && pick_found;
  assign refuse      = arrive_live && !pick_found;
  assign leave_hit   = car_leave && occ_q[leave_slot];
  assign leave_miss  = car_leave && !occ_q[leave_slot];

  // Grant looks only at pre-leave occupancy, so the two indices never collide.
  always_comb begin
    occ_d  = occ_q;
    free_d = free_q;
    if (grant) begin
      occ_d[pick_idx] = 1'b1;
    end
    if (leave_hit) begin
      occ_d[leave_slot] = 1'b0;
    end
    case ({grant, leave_hit})
      2'b10:   free_d = free_q - 1'b1;
      2'b01:   free_d = free_q + 1'b1;
      default: free_d = free_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q          <= '0;
      free_q         <= (SLOT_W + 1)'(NUM_SLOTS);
      state_q        <= IDLE;
      timer_q        <= '0;
      sensor_entry_q <= 1'b0;
      entry_slot_q   <= '0;
      want_q         <= 1'b0;
      sensor_exit_q  <= 1'b0;
      exit_slot_q    <= '0;
      reject_q       <= 1'b0;
      leave_err_q    <= 1'b0;
    end else begin
      occ_q          <= occ_d;
      free_q         <= free_d;
      sensor_entry_q <= grant;
      sensor_exit_q  <= leave_hit;
      reject_q       <= refuse;
      leave_err_q    <= leave_miss;
      if (grant) begin
        entry_slot_q <= pick_idx;
        want_q       <= arrive_charge;
      end
      if (leave_hit) begin
        exit_slot_q <= leave_slot;
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= OPEN;
            timer_q <= TIMER_W'(GATE_CYCLES - 1);
          end
        end
        OPEN: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sensor_entry   = sensor_entry_q;
  assign entry_slot     = entry_slot_q;
  assign want_to_charge = want_q;
  assign sensor_exit    = sensor_exit_q;
  assign exit_slot      = exit_slot_q;
  assign reject         = reject_q;
  assign leave_err      = leave_err_q;
  assign gate_open      = (state_q == OPEN);
  assign lot_full       = &occ_q;
  assign free_count     = free_q;

endmodule

// File: tb/tb_slot_allocator.sv
// tb/tb_slot_allocator.sv - directed and random checks of slot_allocator against a behavioural lot model
module tb_slot_allocator;

  localparam int NSLOT = 16;
  localparam int CHG   = 4;
  localparam int GATE  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_arrive = 1'b0, arrive_charge = 1'b0, car_leave = 1'b0;
  logic [3:0] leave_slot = '0;
  logic       sensor_entry, want_to_charge, sensor_exit, reject, leave_err, gate_open, lot_full;
  logic [3:0] entry_slot, exit_slot;
  logic [4:0] free_count;

  int checks = 0;
  int errors = 0;

  // Lot model: which slots hold cars, how many gate cycles remain, last pulses.
  bit m_occ[NSLOT];
  int m_free, m_gate, m_entry_slot, m_exit_slot;
  bit m_want, e_entry, e_exit, e_rej, e_lerr;

  slot_allocator #(.CHARGE_SLOTS(CHG), .GATE_CYCLES(GATE)) dut (
    .clk(clk), .rst(rst),
    .car_arrive(car_arrive), .arrive_charge(arrive_charge),
    .car_leave(car_leave), .leave_slot(leave_slot),
    .sensor_entry(sensor_entry), .entry_slot(entry_slot), .want_to_charge(want_to_charge),
    .sensor_exit(sensor_exit), .exit_slot(exit_slot),
    .reject(reject), .leave_err(leave_err),
    .gate_open(gate_open), .lot_full(lot_full), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int first_free(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (!m_occ[i]) return i;
    return -1;
  endfunction

  function automatic int model_pick(input bit chg);
`ifdef SLOT_CHARGE_PRIORITY_EN
    int p;
    if (chg) return first_free(0, CHG - 1);
    p = first_free(CHG, NSLOT - 1);
    if (p < 0) p = first_free(0, CHG - 1);
    return p;
`else
    return first_free(0, NSLOT - 1);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) m_occ[i] = 0;
    m_free = NSLOT; m_gate = 0; m_entry_slot = 0; m_exit_slot = 0; m_want = 0;
    e_entry = 0; e_exit = 0; e_rej = 0; e_lerr = 0;
  endtask

  task automatic model_step(input bit arr, input bit chg, input bit lv, input int slot);
    bit busy;
    int p;
    busy = (m_gate > 0);
    e_entry = 0; e_exit = 0; e_rej = 0; e_lerr = 0;
    p = -1;
    if (busy) m_gate--;
    if (arr && !busy) begin
      p = model_pick(chg);
      if (p < 0) e_rej = 1;
      else begin
        e_entry = 1; m_entry_slot = p; m_want = chg; m_gate = GATE;
      end
    end
    if (lv) begin
      if (m_occ[slot]) begin e_exit = 1; m_exit_slot = slot; end
      else e_lerr = 1;
    end
    if (e_entry) begin m_occ[p] = 1; m_free--; end
    if (e_exit) begin m_occ[slot] = 0; m_free++; end
  endtask

  task automatic check_outputs(input bit chk_want);
    chk("sensor_entry", 8'(sensor_entry), 8'(e_entry));
    chk("entry_slot", 8'(entry_slot), 8'(m_entry_slot));
    if (chk_want) chk("want_to_charge", 8'(want_to_charge), 8'(m_want));
    chk("sensor_exit", 8'(sensor_exit), 8'(e_exit));
    chk("exit_slot", 8'(exit_slot), 8'(m_exit_slot));
    chk("reject", 8'(reject), 8'(e_rej));
    chk("leave_err", 8'(leave_err), 8'(e_lerr));
    chk("gate_open", 8'(gate_open), 8'(m_gate > 0));
    chk("lot_full", 8'(lot_full), 8'(m_free == 0));
    chk("free_count", 8'(free_count), 8'(m_free));
  endtask

  task automatic step(input bit arr, input bit chg, input bit lv, input int slot);
    car_arrive = arr; arrive_charge = chg; car_leave = lv; leave_slot = 4'(slot);
    @(posedge clk);
    #1;
    model_step(arr, chg, lv, slot);
    check_outputs(e_entry);
    car_arrive = 0; arrive_charge = 0; car_leave = 0; leave_slot = '0;
  endtask

  // Assert reset between edges, check the async effect, release after the next edge.
  task automatic do_reset();
    rst = 1;
    #2;
    model_reset();
    check_outputs(1'b1);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic spaced_arrive(input bit chg);
    step(1, chg, 0, 0);
    repeat (GATE + 1) step(0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    step(1, 0, 0, 0);
    chk("first_grant_slot0", 8'(entry_slot), 8'd0);
    repeat (GATE) step(0, 0, 0, 0);
    chk("gate_closed_after_8", 8'(gate_open), 8'd0);
    step(0, 0, 0, 0);

    for (int i = 1; i < NSLOT; i++) spaced_arrive(0);
    chk("lot_full_after_16", 8'(lot_full), 8'd1);
    step(1, 0, 0, 0);

    step(1, 0, 1, 5);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("regrant_slot5", 8'(entry_slot), 8'd5);
    repeat (GATE + 1) step(0, 0, 0, 0);

    step(0, 0, 1, 9);
    step(0, 0, 1, 9);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

`ifdef SLOT_CHARGE_PRIORITY_EN
    do_reset();
    for (int i = 0; i < CHG; i++) spaced_arrive(1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("noncharger_slot4", 8'(entry_slot), 8'd4);
    repeat (GATE + 1) step(0, 0, 0, 0);
`endif

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, NSLOT - 1)));
    end

    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    do_reset();
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
